mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V pipeline. Sits directly downstream of the execute stage and its EX/MEM register.
- Takes the ALU result as the address and the forwarded rs2 value as store data.
- Drives the data-memory bus through a req/gnt/rvalid handshake and aligns, sign- or zero-extends load data.
- Produces the registered MEM/WB outputs, and raises stall_out to the hazard unit while a memory access is in flight.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RISC-V pipeline: drives the data-memory
// req/gnt/rvalid bus, aligns and extends load data, and registers the MEM/WB outputs.
module mem_stage #(
    parameter int XLEN            = 32,
    parameter bit EXC_ON_MISALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

    state_e          state_q, state_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]      dmem_be_q, dmem_be_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            misalign_exc_q, misalign_exc_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            memop, is_load, is_byte, is_half, misaligned, aligned, ld_signed;
    logic [1:0]      off;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata, ld_ext;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin : decode
        memop      = in_valid & (mem_read | mem_write);
        is_load    = mem_read;
        is_byte    = (funct3[1:0] == 2'b00);
        is_half    = (funct3[1:0] == 2'b01);
        ld_signed  = ~funct3[2];
        misaligned = is_half ? alu_result[0] : (!is_byte && (alu_result[1:0] != 2'b00));
        aligned    = !misaligned || !EXC_ON_MISALIGN;

        // Aligned accesses already have zero low bits, so forcing them only matters
        // when misaligned accesses are let through.
        off = alu_result[1:0];
        if (is_half) begin
            off[0] = 1'b0;
        end else if (!is_byte) begin
            off = 2'b00;
        end

        st_be    = 4'b1111;
        st_wdata = store_data;
        if (is_byte) begin
            st_be    = 4'b0001 << off;
            st_wdata = {4{store_data[7:0]}};
        end else if (is_half) begin
            st_be    = 4'b0011 << off;
            st_wdata = {2{store_data[15:0]}};
        end
        if (is_load) begin
            st_be = 4'b1111;
        end

        ld_byte = dmem_rdata[{off, 3'b000} +: 8];
        ld_half = dmem_rdata[{off[1], 4'b0000} +: 16];
        if (is_byte) begin
            ld_ext = {{(XLEN-8){ld_signed & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            ld_ext = {{(XLEN-16){ld_signed & ld_half[15]}}, ld_half};
        end else begin
            ld_ext = dmem_rdata;
        end

        stall_out = memop && aligned && (state_q != DONE);
    end

    always_comb begin : next_state
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        load_data_d    = load_data_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        wb_data_d      = wb_data_q;
        misalign_exc_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop && aligned) begin
                    state_d      = REQ;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = !is_load;
                    dmem_addr_d  = {alu_result[XLEN-1:2], 2'b00};
                    dmem_be_d    = st_be;
                    dmem_wdata_d = st_wdata;
                end else if (memop) begin
                    misalign_exc_d = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd;
                    wb_data_d      = alu_result;
                end else begin
                    wb_valid_d     = in_valid;
                    wb_rd_d        = rd;
                    wb_reg_write_d = reg_write & in_valid;
                    wb_data_d      = alu_result;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    state_d    = dmem_we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    load_data_d = ld_ext;
                    state_d     = DONE;
                end
            end
            DONE: begin
                wb_valid_d     = 1'b1;
                wb_rd_d        = rd;
                wb_reg_write_d = reg_write & is_load;
                wb_data_d      = is_load ? load_data_q : alu_result;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block with no rst_n in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_be_q      <= '0;
            dmem_wdata_q   <= '0;
            load_data_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            misalign_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            load_data_q    <= load_data_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            misalign_exc_q <= misalign_exc_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign misalign_exc = misalign_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single transactions against a
// small bus/memory responder, plus reset-mid-access and store-then-load sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write, misalign_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .rd(rd), .reg_write(reg_write),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .misalign_exc(misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          rd_en;
        bit          wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [4:0]  rd;
        bit          rw;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          wb_valid;
        bit          wb_rw;
        logic [31:0] wb_data;
        bit          chk_data;
        bit          exc;
        int          stall;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int total = 0;
    int bad = 0;
    int gnt_total = 0;
    logic [31:0] mem_model [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx, input bit preload, input bit bubble_after);
        int          stall_cnt, req_cnt, cyc, gnt_cyc;
        bit          granted, rv_done, saw_req, done, unstable, expect_req;
        logic [31:0] cap_addr, cap_wdata, w;
        logic [3:0]  cap_be;
        logic        cap_we;
        stall_cnt = 0; req_cnt = 0; cyc = 0; gnt_cyc = 0;
        granted = 1'b0; rv_done = 1'b0; saw_req = 1'b0; done = 1'b0; unstable = 1'b0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        expect_req = v.valid && (v.rd_en || v.wr_en) && !v.exc;

        in_valid = v.valid; mem_read = v.rd_en; mem_write = v.wr_en; funct3 = v.f3;
        alu_result = v.addr; store_data = v.sdata; rd = v.rd; reg_write = v.rw;
        if (preload && v.rd_en) mem_model[v.addr[31:2]] = v.rdata;

        while (!done && cyc < 100) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
            if (stall_out) stall_cnt++;
            if (granted && !rv_done && !cap_we && cyc >= gnt_cyc + v.rv_dly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem_model[cap_addr[31:2]];
                rv_done     = 1'b1;
            end
            if (dmem_req && !granted) begin
                if (!saw_req) begin
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
                end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata ||
                             dmem_be !== cap_be || dmem_we !== cap_we) begin
                    unstable = 1'b1;
                end
                saw_req = 1'b1;
                req_cnt++;
                if (req_cnt > v.gnt_dly) begin
                    dmem_gnt = 1'b1; granted = 1'b1; gnt_cyc = cyc; gnt_total++;
                    if (cap_we) begin
                        w = mem_model.exists(cap_addr[31:2]) ? mem_model[cap_addr[31:2]] : 32'h0;
                        for (int b = 0; b < 4; b++) if (cap_be[b]) w[8*b +: 8] = cap_wdata[8*b +: 8];
                        mem_model[cap_addr[31:2]] = w;
                    end
                end
            end
            if (!stall_out) done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end

        check($sformatf("vec%0d completed", idx), 32'(done), 32'd1);
        check($sformatf("vec%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.stall));
        check($sformatf("vec%0d saw_req", idx), 32'(saw_req), 32'(expect_req));
        if (expect_req) begin
            check($sformatf("vec%0d dmem_addr", idx), cap_addr, {v.addr[31:2], 2'b00});
            check($sformatf("vec%0d dmem_be", idx), 32'(cap_be), 32'(v.be));
            check($sformatf("vec%0d dmem_we", idx), 32'(cap_we), 32'(v.wr_en && !v.rd_en));
            if (v.wr_en) check($sformatf("vec%0d dmem_wdata", idx), cap_wdata, v.wdata);
            check($sformatf("vec%0d bus_stable", idx), 32'(unstable), 32'd0);
        end
        check($sformatf("vec%0d wb_valid", idx), 32'(wb_valid), 32'(v.wb_valid));
        check($sformatf("vec%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
        check($sformatf("vec%0d wb_reg_write", idx), 32'(wb_reg_write), 32'(v.wb_rw));
        if (v.chk_data) check($sformatf("vec%0d wb_data", idx), wb_data, v.wb_data);
        check($sformatf("vec%0d misalign_exc", idx), 32'(misalign_exc), 32'(v.exc));
        check($sformatf("vec%0d dmem_req_idle", idx), 32'(dmem_req), 32'd0);

        if (bubble_after) begin
            in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            @(posedge clk); #1;
            check($sformatf("vec%0d exc_pulse_end", idx), 32'(misalign_exc), 32'd0);
            check($sformatf("vec%0d bubble_wb_valid", idx), 32'(wb_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sw_v, lw_v;
        int   gnt_base;

        //          val   rd    wr    f3      addr          sdata         rdata        gd rv rd     rw    be       wdata         wbv   wbrw  wb_data       chk   exc   stall
        vecs[0]  = '{1'b1,1'b0,1'b0,3'b000,32'h0000_1234,32'h0,       32'h0,       0,0,5'd5, 1'b1,4'b0000,32'h0,       1'b1,1'b1,32'h0000_1234,1'b1,1'b0,0};
        vecs[1]  = '{1'b1,1'b0,1'b1,3'b000,32'h0000_0103,32'hAABBCCDD,32'h0,       0,0,5'd7, 1'b1,4'b1000,32'hDDDDDDDD,1'b1,1'b0,32'h0000_0103,1'b1,1'b0,2};
        vecs[2]  = '{1'b1,1'b1,1'b0,3'b000,32'h0000_0202,32'h0,       32'h00800000,3,2,5'd10,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'hFFFF_FF80,1'b1,1'b0,7};
        vecs[3]  = '{1'b1,1'b1,1'b0,3'b100,32'h0000_0202,32'h0,       32'h00800000,3,2,5'd11,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'h0000_0080,1'b1,1'b0,7};
        vecs[4]  = '{1'b1,1'b1,1'b0,3'b001,32'h0000_0002,32'h0,       32'h80010000,0,1,5'd12,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'hFFFF_8001,1'b1,1'b0,3};
        vecs[5]  = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0006,32'h0,       32'h0,       0,0,5'd13,1'b1,4'b0000,32'h0,       1'b1,1'b0,32'h0000_0006,1'b0,1'b1,0};
        vecs[6]  = '{1'b1,1'b0,1'b1,3'b001,32'h0000_0022,32'h1234ABCD,32'h0,       1,0,5'd14,1'b1,4'b1100,32'hABCDABCD,1'b1,1'b0,32'h0000_0022,1'b1,1'b0,3};
        vecs[7]  = '{1'b1,1'b1,1'b0,3'b101,32'h0000_0002,32'h0,       32'h80010000,0,1,5'd15,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'h0000_8001,1'b1,1'b0,3};
        vecs[8]  = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0040,32'h0,       32'h89ABCDEF,0,3,5'd16,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'h89AB_CDEF,1'b1,1'b0,5};
        vecs[9]  = '{1'b1,1'b0,1'b1,3'b010,32'h0000_0044,32'hCAFEF00D,32'h0,       2,0,5'd17,1'b0,4'b1111,32'hCAFEF00D,1'b1,1'b0,32'h0000_0044,1'b1,1'b0,4};
        vecs[10] = '{1'b1,1'b1,1'b0,3'b000,32'h0000_0201,32'h0,       32'h00007F00,1,1,5'd18,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'h0000_007F,1'b1,1'b0,4};
        vecs[11] = '{1'b1,1'b0,1'b1,3'b001,32'h0000_0101,32'h0000BEEF,32'h0,       0,0,5'd19,1'b1,4'b0000,32'h0,       1'b1,1'b0,32'h0000_0101,1'b0,1'b1,0};
        vecs[12] = '{1'b0,1'b1,1'b0,3'b010,32'h0000_0050,32'h0,       32'h0,       0,0,5'd20,1'b1,4'b0000,32'h0,       1'b0,1'b0,32'h0000_0050,1'b1,1'b0,0};
        vecs[13] = '{1'b1,1'b1,1'b0,3'b011,32'h0000_0048,32'h0,       32'h13572468,0,1,5'd21,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'h1357_2468,1'b1,1'b0,3};
        vecs[14] = '{1'b1,1'b0,1'b1,3'b000,32'h0000_0061,32'h000000A5,32'h0,       0,0,5'd22,1'b1,4'b0010,32'hA5A5A5A5,1'b1,1'b0,32'h0000_0061,1'b1,1'b0,2};

        sw_v = '{1'b1,1'b0,1'b1,3'b010,32'h0000_0010,32'h5A5AC3C3,32'h0,0,0,5'd1,1'b0,4'b1111,32'h5A5AC3C3,1'b1,1'b0,32'h0000_0010,1'b1,1'b0,2};
        lw_v = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0010,32'h0,       32'h0,1,1,5'd2,1'b1,4'b1111,32'h0,       1'b1,1'b1,32'h5A5A_C3C3,1'b1,1'b0,4};

        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        funct3 = 3'b000; alu_result = '0; store_data = '0; rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        check("reset stall_out", 32'(stall_out), 32'd0);
        check("reset dmem_req", 32'(dmem_req), 32'd0);
        check("reset dmem_we", 32'(dmem_we), 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        check("reset dmem_be", 32'(dmem_be), 32'd0);
        check("reset dmem_wdata", dmem_wdata, 32'd0);
        check("reset wb_valid", 32'(wb_valid), 32'd0);
        check("reset wb_rd", 32'(wb_rd), 32'd0);
        check("reset wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset misalign_exc", 32'(misalign_exc), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) do_txn(vecs[i], i, 1'b1, 1'b1);

        // Reset while a load sits in WAIT_R; the late rvalid must be ignored.
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_0080; rd = 5'd3; reg_write = 1'b1;
        @(negedge clk);
        check("rst_seq idle stall", 32'(stall_out), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rst_seq wait stall", 32'(stall_out), 32'd1);
        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        check("rst_seq dmem_req", 32'(dmem_req), 32'd0);
        check("rst_seq stall_out", 32'(stall_out), 32'd0);
        check("rst_seq wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        check("rst_seq late_rv wb_valid", 32'(wb_valid), 32'd0);
        check("rst_seq late_rv dmem_req", 32'(dmem_req), 32'd0);
        check("rst_seq late_rv stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("rst_seq after wb_valid", 32'(wb_valid), 32'd0);
        check("rst_seq after wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst_seq after dmem_req", 32'(dmem_req), 32'd0);

        // Back-to-back SW then LW to the same word through the memory model.
        gnt_base = gnt_total;
        do_txn(sw_v, 100, 1'b0, 1'b0);
        do_txn(lw_v, 101, 1'b0, 1'b1);
        check("b2b gnt_count", 32'(gnt_total - gnt_base), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
